// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared definitions for the PID controller / plant front end
//
// Purpose: widths, the shadow-register state type and PWM constants shared by
//          the PID controller and pid_plant_io.
// Contents:
//   DUTY_W, FB_W       control word and feedback sample widths
//   PWM_MAX            terminal value of the 8-bit PWM counter
//   shadow_state_e     EMPTY / FULL state of the duty shadow register
//   sat_inc()          saturating increment used by the tach counter
package pid_pkg;

  localparam int DUTY_W = 8;
  localparam int FB_W   = 8;

  localparam logic [7:0] PWM_MAX = 8'hFF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } shadow_state_e;

  // Adds inc to v, sticking at all-ones instead of wrapping.
  function automatic logic [FB_W-1:0] sat_inc(input logic [FB_W-1:0] v,
                                               input logic            inc);
    logic [FB_W-1:0] r;
    r = v;
    if (inc && (v != {FB_W{1'b1}})) begin
      r = v + FB_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/tach_counter.sv
// rtl/tach_counter.sv - tachometer synchronizer, optional glitch filter, edge counter
//
// Purpose: brings the asynchronous tach pulse train into the clk domain,
//          detects rising edges and counts them with saturation at all-ones.
// Build option: TACH_GLITCH_FILTER_EN inserts a 3-cycle stability filter
//               between the synchronizer and the edge detector.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   tach_in  in   asynchronous tachometer input
//   clear    in   zero the stored count at the end of this cycle
//   count    out  stored count plus an edge detected in this cycle (saturating)
module tach_counter
  import pid_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tach_in,
  input  logic            clear,
  output logic [FB_W-1:0] count
);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic            level_d;
  logic            rise;
  logic [FB_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= tach_in;
      sync2 <= sync1;
    end
  end

`ifdef TACH_GLITCH_FILTER_EN
  // The filtered level follows sync2 only after sync2 has disagreed with it
  // for three consecutive clocks; any return to agreement restarts the run.
  logic [1:0] run_q;
  logic       filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 2'd0;
      filt_q <= 1'b0;
    end else if (sync2 == filt_q) begin
      run_q <= 2'd0;
    end else if (run_q == 2'd2) begin
      filt_q <= sync2;
      run_q  <= 2'd0;
    end else begin
      run_q <= run_q + 2'd1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

  // count already includes this cycle's edge so a window closing on the same
  // cycle as an edge still sees it; the clear then discards it from the next.
  assign count = sat_inc(cnt_q, rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= count;
    end
  end

endmodule

// File: rtl/pid_plant_io.sv
// rtl/pid_plant_io.sv - plant-side PWM actuator and tach feedback front end
//
// Purpose: accepts duty words from the PID controller over valid/ready,
//          double-buffers them so they change only on PWM period boundaries,
//          drives a registered PWM output and returns a tach pulse count once
//          per measurement window.
// Build option: TACH_GLITCH_FILTER_EN (see tach_counter).
// Parameters:
//   PRESCALE  clk cycles per PWM tick, 1..256
//   WINDOW    PWM periods per feedback window, 1..256
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   duty_in       in   control word
//   duty_valid    in   duty_in valid
//   duty_ready    out  shadow register empty
//   pwm_out       out  registered PWM drive
//   period_start  out  one-cycle pulse at the start of each PWM period
//   tach_in       in   asynchronous tachometer input
//   fb_out        out  latest feedback sample
//   fb_valid      out  one-cycle pulse when fb_out updates
module pid_plant_io
  import pid_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int WINDOW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_start,
  input  logic              tach_in,
  output logic [FB_W-1:0]   fb_out,
  output logic              fb_valid
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic [PRE_W-1:0]  pre_cnt;
  logic [7:0]        pwm_cnt;
  logic [7:0]        pwm_cnt_nxt;
  logic [WIN_W-1:0]  win_cnt;
  logic              tick;
  logic              boundary;
  logic              window_end;
  logic              accept;

  shadow_state_e     state;
  logic [DUTY_W-1:0] shadow;
  logic [DUTY_W-1:0] active_duty;
  logic [DUTY_W-1:0] active_nxt;
  logic [FB_W-1:0]   tach_count;

  // ---------------------------------------------------------------- timebase
  assign tick        = (pre_cnt == PRE_LAST);
  assign boundary    = tick && (pwm_cnt == PWM_MAX);
  assign window_end  = boundary && (win_cnt == WIN_LAST);
  assign pwm_cnt_nxt = tick ? (pwm_cnt + 8'd1) : pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      pre_cnt <= tick ? '0 : (pre_cnt + PRE_W'(1));
      pwm_cnt <= pwm_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (boundary) begin
      win_cnt <= (win_cnt == WIN_LAST) ? '0 : (win_cnt + WIN_W'(1));
    end
  end

  // ------------------------------------------------------ duty double buffer
  assign duty_ready = (state == EMPTY);
  assign accept     = duty_valid && duty_ready;

  // A word accepted on a boundary cycle lands in shadow only, because the
  // transfer below looks at the registered state, which is still EMPTY.
  assign active_nxt = (boundary && (state == FULL)) ? shadow : active_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      shadow      <= '0;
      active_duty <= '0;
    end else begin
      active_duty <= active_nxt;
      case (state)
        EMPTY: begin
          if (accept) begin
            shadow <= duty_in;
            state  <= FULL;
          end
        end
        FULL: begin
          if (boundary) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Compare against next-state values so the new duty and the new period
  // appear together with period_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= (pwm_cnt_nxt < active_nxt);
      period_start <= boundary;
    end
  end

  // ---------------------------------------------------------------- feedback
  tach_counter u_tach (
    .clk     (clk),
    .rst_n   (rst_n),
    .tach_in (tach_in),
    .clear   (window_end),
    .count   (tach_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_out   <= '0;
      fb_valid <= 1'b0;
    end else begin
      fb_valid <= window_end;
      if (window_end) begin
        fb_out <= tach_count;
      end
    end
  end

endmodule

// File: tb/tb_pid_plant_io.sv
// tb/tb_pid_plant_io.sv - self-checking bench for pid_plant_io
module tb_pid_plant_io;

  localparam int PRESCALE = 1;
  localparam int WINDOW   = 8;
  localparam int WIN_CYC  = WINDOW * 256 * PRESCALE;
`ifdef TACH_GLITCH_FILTER_EN
  localparam int LEND      = 5;
  localparam int GLITCH_EXP = 0;
`else
  localparam int LEND      = 2;
  localparam int GLITCH_EXP = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       period_start;
  logic       tach_in;
  logic [7:0] fb_out;
  logic       fb_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int fbv_extra;

  typedef struct {
    string      name;
    logic [7:0] duty;
    int         exp_hi;
    int         exp_first;
  } pwm_vec_t;

  pwm_vec_t vecs[5];

  pid_plant_io #(.PRESCALE(PRESCALE), .WINDOW(WINDOW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .tach_in      (tach_in),
    .fb_out       (fb_out),
    .fb_valid     (fb_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Asserts reset away from a clock edge, checks the async reset values,
  // releases at a negedge and measures the first period_start (cycle 1 is the
  // cycle in which rst_n is first high).
  task automatic do_reset(input string tag);
    int cyc;
    int fbv;
    #1 rst_n = 1'b0;
    #1;
    chk({tag, "_pwm_out"}, pwm_out, 0);
    chk({tag, "_period_start"}, period_start, 0);
    chk({tag, "_duty_ready"}, duty_ready, 1);
    chk({tag, "_fb_valid"}, fb_valid, 0);
    chk({tag, "_fb_out"}, fb_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 1;
    fbv = 0;
    while (!period_start && cyc < 2000) begin
      if (fb_valid) fbv++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_first_period_start_cycle"}, cyc, 256 * PRESCALE + 1);
    chk({tag, "_fb_valid_pulses"}, fbv, 0);
  endtask

  task automatic send_word(input logic [7:0] w);
    int g;
    duty_in    = w;
    duty_valid = 1'b1;
    g = 0;
    while (!duty_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("send_ready_seen", duty_ready, 1);
    @(negedge clk);
    duty_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int g;
    g = 0;
    @(negedge clk);
    while (!period_start && g < 600) begin
      @(negedge clk);
      g++;
    end
    chk("period_start_seen", period_start, 1);
  endtask

  task automatic wait_fb();
    int g;
    g = 0;
    @(negedge clk);
    while (!fb_valid && g < WIN_CYC + 500) begin
      @(negedge clk);
      g++;
    end
    chk("fb_valid_seen", fb_valid, 1);
  endtask

  // Counts pwm_out highs over one 256-cycle period starting at the current
  // negedge; drops duty_valid after the first edge.
  task automatic count_hi(output int hi, output int first);
    hi = 0;
    first = pwm_out;
    for (int i = 0; i < 256; i++) begin
      hi += int'(pwm_out);
      @(negedge clk);
      duty_valid = 1'b0;
    end
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      tach_in = 1'b1;
      repeat (hi) begin
        @(negedge clk);
        if (fb_valid) fbv_extra++;
      end
      tach_in = 1'b0;
      repeat (lo) begin
        @(negedge clk);
        if (fb_valid) fbv_extra++;
      end
    end
  endtask

  initial begin
    int hi;
    int first;
    int stall;
    int g;

    vecs[0] = '{"duty_40", 8'h40, 64, 1};
    vecs[1] = '{"duty_00", 8'h00, 0, 0};
    vecs[2] = '{"duty_ff", 8'hFF, 255, 1};
    vecs[3] = '{"duty_01", 8'h01, 1, 1};
    vecs[4] = '{"duty_80", 8'h80, 128, 1};

    rst_n      = 1'b0;
    duty_in    = 8'h00;
    duty_valid = 1'b0;
    tach_in    = 1'b0;
    fbv_extra  = 0;

    do_reset("reset");

    // Table-driven duty patterns; each starts at a period_start negedge.
    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].duty);
      chk({vecs[v].name, "_stall_after_accept"}, duty_ready, 0);
      wait_ps();
      count_hi(hi, first);
      chk({vecs[v].name, "_high_count"}, hi, vecs[v].exp_hi);
      chk({vecs[v].name, "_first_sample"}, first, vecs[v].exp_first);
    end

    // Back-to-back 0x20 then 0x80: second word stalls until the boundary.
    duty_in    = 8'h20;
    duty_valid = 1'b1;
    @(negedge clk);
    duty_in = 8'h80;
    stall = 0;
    while (!duty_ready && stall < 1000) begin
      stall++;
      @(negedge clk);
    end
    chk("b2b_stall_cycles", stall, 256 * PRESCALE - 1);
    chk("b2b_ready_with_period_start", period_start, 1);
    count_hi(hi, first);
    chk("b2b_first_word_high", hi, 32);
    chk("b2b_period_start_2", period_start, 1);
    count_hi(hi, first);
    chk("b2b_second_word_high", hi, 128);

    // Accept on the boundary cycle: takes effect one period later.
    repeat (255) @(negedge clk);
    chk("bnd_ready_on_boundary", duty_ready, 1);
    duty_in    = 8'h10;
    duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    chk("bnd_period_start", period_start, 1);
    chk("bnd_word_in_shadow", duty_ready, 0);
    count_hi(hi, first);
    chk("bnd_old_duty_high", hi, 128);
    count_hi(hi, first);
    chk("bnd_new_duty_high", hi, 16);

    // Tach: 37 pulses of 4/4 in one window.
    wait_fb();
    fbv_extra = 0;
    pulses(37, 4, 4);
    wait_fb();
    chk("tach37_fb_out", fb_out, 37);
    chk("tach37_extra_fb_valid", fbv_extra, 0);
    @(negedge clk);
    chk("tach37_fb_valid_one_cycle", fb_valid, 0);

    // 300 pulses saturate the 8-bit count.
    pulses(300, 3, 3);
    wait_fb();
    chk("tach300_fb_out", fb_out, 255);

    // 2-cycle glitches: rejected by the filter, counted without it.
    pulses(10, 2, 2);
    wait_fb();
    chk("glitch_fb_out", fb_out, GLITCH_EXP);

    // Edge detected exactly on the window-end cycle counts for the closing
    // window and not for the next one.
    pulses(5, 4, 4);
    g = WIN_CYC - LEND - 1 - 40;
    repeat (g) @(negedge clk);
    tach_in = 1'b1;
    repeat (LEND + 1) @(negedge clk);
    chk("wend_fb_valid", fb_valid, 1);
    chk("wend_fb_out", fb_out, 6);
    @(negedge clk);
    tach_in = 1'b0;
    wait_fb();
    chk("wend_next_window", fb_out, 0);

    // Asynchronous reset in mid-period with the output high.
    send_word(8'h10);
    wait_ps();
    repeat (3) @(negedge clk);
    chk("mid_pwm_high_before_reset", pwm_out, 1);
    do_reset("midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
